// File: rtl/jtag_tap_target.sv
// ---------------------------------------------------------------------------
// jtag_tap_target
//
// IEEE 1149.1 style TAP controller with a 1-bit bypass register, a
// user-defined data register and a boundary-scan data register. All state
// advances on the rising edge of clk (TCK). The data registers are shifted
// LSB first: Tdi enters at the MSB and Tdo is the LSB of the active register.
//
// Parameters
//   INSTRUCTION_WIDTH  instruction register length (3..5)
//   TEST_VECTOR_WIDTH  user / boundary-scan register length (8, 16, 24, 32)
//
// Ports
//   clk              in   TCK
//   reset            in   asynchronous active-high reset of the whole block
//   Trst             in   (JTAG_TRST_EN only) active-low async TAP-only reset
//   Tms              in   test mode select
//   Tdi              in   serial data in
//   Tdo              out  serial data out (0 outside the shift states)
//   tdoEnable        out  high in shiftIr / shiftDr
//   boundaryScanIn   in   parallel value captured into the boundary register
//   tapState         out  current TAP state, 0 (reset) .. 15 (updateDr)
//   instructionOut   out  latched instruction
//   userRegOut       out  updated user-defined register
//   boundaryScanOut  out  updated boundary-scan register
//   updateDrPulse    out  high for the one cycle spent in updateDr
//
// Configuration macro
//   JTAG_TRST_EN     adds the Trst port. Trst only resets the TAP state and
//                    the instruction; the parallel data outputs are kept.
// ---------------------------------------------------------------------------
module jtag_tap_target #(
  parameter int INSTRUCTION_WIDTH = 5,
  parameter int TEST_VECTOR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef JTAG_TRST_EN
  input  logic                         Trst,
`endif
  input  logic                         Tms,
  input  logic                         Tdi,
  output logic                         Tdo,
  output logic                         tdoEnable,
  input  logic [TEST_VECTOR_WIDTH-1:0] boundaryScanIn,
  output logic [3:0]                   tapState,
  output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
  output logic [TEST_VECTOR_WIDTH-1:0] userRegOut,
  output logic [TEST_VECTOR_WIDTH-1:0] boundaryScanOut,
  output logic                         updateDrPulse
);

  typedef enum logic [3:0] {
    stReset     = 4'd0,
    stIdle      = 4'd1,
    stDrScan    = 4'd2,
    stIrScan    = 4'd3,
    stCaptureIr = 4'd4,
    stShiftIr   = 4'd5,
    stExit1Ir   = 4'd6,
    stPauseIr   = 4'd7,
    stExit2Ir   = 4'd8,
    stUpdateIr  = 4'd9,
    stCaptureDr = 4'd10,
    stShiftDr   = 4'd11,
    stExit1Dr   = 4'd12,
    stPauseDr   = 4'd13,
    stExit2Dr   = 4'd14,
    stUpdateDr  = 4'd15
  } tapState_t;

  typedef enum logic [1:0] {
    drBypass,
    drUser,
    drBoundary
  } drSel_t;

  // Opcodes are defined on 5 bits and truncated to the configured IR length.
  localparam logic [INSTRUCTION_WIDTH-1:0] OPCODE_BYPASS   = '0;
  localparam logic [INSTRUCTION_WIDTH-1:0] OPCODE_USER     = INSTRUCTION_WIDTH'(5'b00001);
  localparam logic [INSTRUCTION_WIDTH-1:0] OPCODE_BOUNDARY = INSTRUCTION_WIDTH'(5'b00110);
  localparam logic [INSTRUCTION_WIDTH-1:0] IR_CAPTURE      = INSTRUCTION_WIDTH'(2'b01);

  tapState_t                    state;
  tapState_t                    nextState;
  drSel_t                       drSel;
  logic                         tapReset;
  logic [INSTRUCTION_WIDTH-1:0] irShift;
  logic                         bypassReg;
  logic [TEST_VECTOR_WIDTH-1:0] userShift;
  logic [TEST_VECTOR_WIDTH-1:0] boundaryShift;

  // The TAP-only reset covers the state register and the instruction; the
  // data registers and parallel outputs listen to the full reset only.
`ifdef JTAG_TRST_EN
  assign tapReset = reset | ~Trst;
`else
  assign tapReset = reset;
`endif

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge tapReset) begin
    if (tapReset) begin
      state <= stReset;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      stReset:     nextState = Tms ? stReset     : stIdle;
      stIdle:      nextState = Tms ? stDrScan    : stIdle;
      stDrScan:    nextState = Tms ? stIrScan    : stCaptureDr;
      stIrScan:    nextState = Tms ? stReset     : stCaptureIr;
      stCaptureIr: nextState = Tms ? stExit1Ir   : stShiftIr;
      stShiftIr:   nextState = Tms ? stExit1Ir   : stShiftIr;
      stExit1Ir:   nextState = Tms ? stUpdateIr  : stPauseIr;
      stPauseIr:   nextState = Tms ? stExit2Ir   : stPauseIr;
      stExit2Ir:   nextState = Tms ? stUpdateIr  : stShiftIr;
      stUpdateIr:  nextState = Tms ? stDrScan    : stIdle;
      stCaptureDr: nextState = Tms ? stExit1Dr   : stShiftDr;
      stShiftDr:   nextState = Tms ? stExit1Dr   : stShiftDr;
      stExit1Dr:   nextState = Tms ? stUpdateDr  : stPauseDr;
      stPauseDr:   nextState = Tms ? stExit2Dr   : stPauseDr;
      stExit2Dr:   nextState = Tms ? stUpdateDr  : stShiftDr;
      stUpdateDr:  nextState = Tms ? stDrScan    : stIdle;
      default:     nextState = stReset;
    endcase
  end

  always_comb begin
    tdoEnable     = (state == stShiftIr) || (state == stShiftDr);
    updateDrPulse = (state == stUpdateDr);
    Tdo           = 1'b0;
    if (state == stShiftIr) begin
      Tdo = irShift[0];
    end else if (state == stShiftDr) begin
      case (drSel)
        drUser:     Tdo = userShift[0];
        drBoundary: Tdo = boundaryShift[0];
        default:    Tdo = bypassReg;
      endcase
    end
  end

  assign tapState = state;

  // ---------------------------------------------------------- instruction
  // Bypass is loaded on the edge that enters reset, so the instruction is
  // already bypass in the first cycle of the reset state.
  always_ff @(posedge clk or posedge tapReset) begin
    if (tapReset) begin
      instructionOut <= OPCODE_BYPASS;
    end else if (nextState == stReset) begin
      instructionOut <= OPCODE_BYPASS;
    end else if (state == stUpdateIr) begin
      instructionOut <= irShift;
    end
  end

  always_comb begin
    if (instructionOut == OPCODE_USER) begin
      drSel = drUser;
    end else if (instructionOut == OPCODE_BOUNDARY) begin
      drSel = drBoundary;
    end else begin
      drSel = drBypass;
    end
  end

  // ------------------------------------------------------- shift / update
  // Pause and exit states fall through to the default and hold everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irShift         <= '0;
      bypassReg       <= 1'b0;
      userShift       <= '0;
      boundaryShift   <= '0;
      userRegOut      <= '0;
      boundaryScanOut <= '0;
    end else begin
      case (state)
        stCaptureIr: irShift <= IR_CAPTURE;
        stShiftIr:   irShift <= {Tdi, irShift[INSTRUCTION_WIDTH-1:1]};
        stCaptureDr: begin
          case (drSel)
            drUser:     userShift     <= userRegOut;
            drBoundary: boundaryShift <= boundaryScanIn;
            default:    bypassReg     <= 1'b0;
          endcase
        end
        stShiftDr: begin
          case (drSel)
            drUser:     userShift     <= {Tdi, userShift[TEST_VECTOR_WIDTH-1:1]};
            drBoundary: boundaryShift <= {Tdi, boundaryShift[TEST_VECTOR_WIDTH-1:1]};
            default:    bypassReg     <= Tdi;
          endcase
        end
        stUpdateDr: begin
          case (drSel)
            drUser:     userRegOut      <= userShift;
            drBoundary: boundaryScanOut <= boundaryShift;
            default:    ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_target.sv
// ---------------------------------------------------------------------------
// tb_jtag_tap_target
//
// Self-checking bench for jtag_tap_target. A behavioural model (transition
// table plus integer shift arithmetic) shadows every clock step; directed
// vectors and sequences add fixed expectations for the key scenarios.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// i.e. before the rising edge that acts on them.
// ---------------------------------------------------------------------------
module tb_jtag_tap_target;

  localparam int IW = 5;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Tms = 1'b1;
  logic          Tdi = 1'b0;
  logic [TW-1:0] boundaryScanIn = '0;
`ifdef JTAG_TRST_EN
  logic          Trst = 1'b1;
`endif
  logic          Tdo;
  logic          tdoEnable;
  logic [3:0]    tapState;
  logic [IW-1:0] instructionOut;
  logic [TW-1:0] userRegOut;
  logic [TW-1:0] boundaryScanOut;
  logic          updateDrPulse;

  always #5 clk = ~clk;

  jtag_tap_target #(
    .INSTRUCTION_WIDTH(IW),
    .TEST_VECTOR_WIDTH(TW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef JTAG_TRST_EN
    .Trst           (Trst),
`endif
    .Tms            (Tms),
    .Tdi            (Tdi),
    .Tdo            (Tdo),
    .tdoEnable      (tdoEnable),
    .boundaryScanIn (boundaryScanIn),
    .tapState       (tapState),
    .instructionOut (instructionOut),
    .userRegOut     (userRegOut),
    .boundaryScanOut(boundaryScanOut),
    .updateDrPulse  (updateDrPulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  // nextTab[state][tms], states numbered reset=0 .. updateDr=15.
  int nextTab [16][2] = '{
    '{1, 0},   '{1, 2},   '{10, 3},  '{4, 0},
    '{5, 6},   '{5, 6},   '{7, 9},   '{7, 8},
    '{5, 9},   '{1, 2},   '{11, 12}, '{11, 12},
    '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}
  };

  int            mState;
  bit [IW-1:0]   mInstr;
  bit [IW-1:0]   mIr;
  bit            mBypass;
  bit [TW-1:0]   mUserSh;
  bit [TW-1:0]   mBsSh;
  bit [TW-1:0]   mUserOut;
  bit [TW-1:0]   mBsOut;

  task automatic modelReset();
    mState = 0; mInstr = '0; mIr = '0; mBypass = 1'b0;
    mUserSh = '0; mBsSh = '0; mUserOut = '0; mBsOut = '0;
  endtask

  // 1 = user register, 2 = boundary register, 0 = bypass
  function automatic int modelSel();
    if (mInstr == IW'(1)) return 1;
    if (mInstr == IW'(6)) return 2;
    return 0;
  endfunction

  function automatic bit modelTdo();
    if (mState == 5) return mIr[0];
    if (mState == 11) begin
      case (modelSel())
        1:       return mUserSh[0];
        2:       return mBsSh[0];
        default: return mBypass;
      endcase
    end
    return 1'b0;
  endfunction

  task automatic modelEdge(input bit tms, input bit tdi);
    int sel;
    sel = modelSel();
    case (mState)
      4:  mIr = IW'(1);
      5:  mIr = (mIr >> 1) | (IW'(tdi) << (IW - 1));
      9:  mInstr = mIr;
      10: if (sel == 1) mUserSh = mUserOut;
          else if (sel == 2) mBsSh = boundaryScanIn;
          else mBypass = 1'b0;
      11: if (sel == 1) mUserSh = (mUserSh >> 1) | (TW'(tdi) << (TW - 1));
          else if (sel == 2) mBsSh = (mBsSh >> 1) | (TW'(tdi) << (TW - 1));
          else mBypass = tdi;
      15: if (sel == 1) mUserOut = mUserSh;
          else if (sel == 2) mBsOut = mBsSh;
      default: ;
    endcase
    mState = nextTab[mState][tms];
    if (mState == 0) mInstr = '0;
  endtask

  task automatic compareModel();
    check("model tapState",        64'(tapState),        64'(mState));
    check("model Tdo",             64'(Tdo),             64'(modelTdo()));
    check("model tdoEnable",       64'(tdoEnable),       64'(mState == 5 || mState == 11));
    check("model updateDrPulse",   64'(updateDrPulse),   64'(mState == 15));
    check("model instructionOut",  64'(instructionOut),  64'(mInstr));
    check("model userRegOut",      64'(userRegOut),      64'(mUserOut));
    check("model boundaryScanOut", 64'(boundaryScanOut), 64'(mBsOut));
  endtask

  // ------------------------------------------------------------ drivers
  bit lastTdo;
  bit lastTdoEn;

  // One TCK cycle: drive, sample pre-edge outputs, advance model, clock.
  task automatic step(input bit tms, input bit tdi);
    @(negedge clk);
    Tms = tms;
    Tdi = tdi;
    #1;
    lastTdo   = Tdo;
    lastTdoEn = tdoEnable;
    compareModel();
    modelEdge(tms, tdi);
    @(posedge clk);
    #1;
  endtask

  // Tms is held high while reset is released so stray edges keep the reset state.
  task automatic resetPulse();
    Tms   = 1'b1;
    reset = 1'b1;
    modelReset();
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // From idle: load an instruction and return to idle.
  task automatic loadIr(input logic [IW-1:0] op);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IW; i++) step(i == IW - 1, op[i]);
    step(1, 0);
    step(0, 0);
  endtask

  // From idle: capture, shift n bits of data, end in updateDr.
  task automatic runDr(input logic [TW-1:0] data, input int n, output logic [TW-1:0] tdoBits);
    tdoBits = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, data[i]);
      tdoBits[i] = lastTdo;
    end
    step(1, 0);
  endtask

  typedef struct {
    bit         tms;
    bit         tdi;
    bit         expTdo;     // sampled before the edge
    bit         expTdoEn;   // sampled before the edge
    logic [3:0] expState;   // after the edge
  } vec_t;

  vec_t          tbl [12];
  logic [TW-1:0] bits;
  logic [IW-1:0] op;
  int            expWalk [5] = '{12, 15, 2, 3, 0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    modelReset();

    // Reset state while reset is held.
    #1;
    check("reset tapState",        64'(tapState),        64'd0);
    check("reset instructionOut",  64'(instructionOut),  64'd0);
    check("reset Tdo",             64'(Tdo),             64'd0);
    check("reset tdoEnable",       64'(tdoEnable),       64'd0);
    check("reset updateDrPulse",   64'(updateDrPulse),   64'd0);
    check("reset userRegOut",      64'(userRegOut),      64'd0);
    check("reset boundaryScanOut", 64'(boundaryScanOut), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // IR load of 00001: Tms 0,1,1,0,0 then four shifts, exit, update, idle.
    tbl[0]  = '{0, 0, 0, 0, 4'd1};
    tbl[1]  = '{1, 0, 0, 0, 4'd2};
    tbl[2]  = '{1, 0, 0, 0, 4'd3};
    tbl[3]  = '{0, 0, 0, 0, 4'd4};
    tbl[4]  = '{0, 0, 0, 0, 4'd5};
    tbl[5]  = '{0, 1, 1, 1, 4'd5};
    tbl[6]  = '{0, 0, 0, 1, 4'd5};
    tbl[7]  = '{0, 0, 0, 1, 4'd5};
    tbl[8]  = '{0, 0, 0, 1, 4'd5};
    tbl[9]  = '{1, 0, 0, 1, 4'd6};
    tbl[10] = '{1, 0, 0, 0, 4'd9};
    tbl[11] = '{0, 0, 0, 0, 4'd1};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].tms, tbl[i].tdi);
      check($sformatf("vec%0d Tdo", i),       64'(lastTdo),   64'(tbl[i].expTdo));
      check($sformatf("vec%0d tdoEnable", i), 64'(lastTdoEn), 64'(tbl[i].expTdoEn));
      check($sformatf("vec%0d tapState", i),  64'(tapState),  64'(tbl[i].expState));
    end
    check("ir load instructionOut", 64'(instructionOut), 64'h01);

    // User register update.
    runDr(32'hA5A5_1234, 32, bits);
    check("user captured old value", 64'(bits),          64'd0);
    check("user updateDr state",     64'(tapState),      64'd15);
    check("user updateDrPulse high", 64'(updateDrPulse), 64'd1);
    step(0, 0);
    check("user updateDrPulse low",  64'(updateDrPulse), 64'd0);
    check("user userRegOut",         64'(userRegOut),    64'hA5A5_1234);

    // Boundary register capture and shift-out.
    loadIr(5'b00110);
    boundaryScanIn = 32'hDEAD_BEEF;
    runDr(32'h1357_9BDF, 32, bits);
    check("boundary Tdo stream",      64'(bits),            64'hDEAD_BEEF);
    check("boundary updateDrPulse",   64'(updateDrPulse),   64'd1);
    step(0, 0);
    check("boundary boundaryScanOut", 64'(boundaryScanOut), 64'h1357_9BDF);
    check("boundary userRegOut kept", 64'(userRegOut),      64'hA5A5_1234);

    // Undefined opcode selects bypass: one-bit delay, nothing updated.
    loadIr(5'b11111);
    check("bypass instructionOut", 64'(instructionOut), 64'h1F);
    runDr(32'h0000_000D, 4, bits);
    check("bypass Tdo 0,1,0,1",     64'(bits[3:0]),     64'hA);
    check("bypass updateDrPulse",   64'(updateDrPulse), 64'd1);
    step(0, 0);
    check("bypass userRegOut kept", 64'(userRegOut),      64'hA5A5_1234);
    check("bypass boundary kept",   64'(boundaryScanOut), 64'h1357_9BDF);

    // Five Tms=1 edges from shiftDr walk to reset.
    step(1, 0); step(0, 0); step(0, 0);
    check("walk start shiftDr", 64'(tapState), 64'd11);
    for (int k = 0; k < 5; k++) begin
      step(1, 0);
      check($sformatf("walk edge%0d tapState", k + 1), 64'(tapState), 64'(expWalk[k]));
    end
    check("walk instructionOut bypass", 64'(instructionOut), 64'd0);

    // Randomized rounds against the model.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 5; k++) step(1, 1'($urandom_range(0, 1)));
      check("random five-Tms reset", 64'(tapState), 64'd0);
      step(0, 0);
      case (r % 3)
        0:       op = IW'(1);
        1:       op = IW'(6);
        default: op = IW'($urandom);
      endcase
      loadIr(op);
      check("random instructionOut", 64'(instructionOut), 64'(op));
      boundaryScanIn = $urandom;
      for (int k = 0; k < 60; k++)
        step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a DR shift discards the partial data.
    resetPulse();
    step(0, 0);
    loadIr(IW'(1));
    step(1, 0); step(0, 0); step(0, 0);
    for (int k = 0; k < 10; k++) step(0, 1'($urandom_range(0, 1)));
    check("midshift in shiftDr", 64'(tapState), 64'd11);
    reset = 1'b1;
    #1;
    check("midshift tapState",        64'(tapState),        64'd0);
    check("midshift instructionOut",  64'(instructionOut),  64'd0);
    check("midshift Tdo",             64'(Tdo),             64'd0);
    check("midshift tdoEnable",       64'(tdoEnable),       64'd0);
    check("midshift updateDrPulse",   64'(updateDrPulse),   64'd0);
    check("midshift userRegOut",      64'(userRegOut),      64'd0);
    check("midshift boundaryScanOut", 64'(boundaryScanOut), 64'd0);
    Tms = 1'b1;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    step(0, 0);
    step(1, 0); step(1, 0);
    check("midshift no late update", 64'(userRegOut), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_target.md
JTAG_TAP_TARGET -- requirements
Module: jtag_tap_target

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 5, instruction register length (3..5).
REQ-002 SHALL have parameter TEST_VECTOR_WIDTH, default 32, length of the user-defined and boundary-scan data registers (8, 16, 24 or 32).
REQ-003 SHALL have port clk  input  1  TCK; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Tms  input  1  test mode select, sampled on the rising edge of clk.
REQ-006 SHALL have port Tdi  input  1  serial data in, LSB first.
REQ-007 SHALL have port Tdo  output  1  serial data out, LSB of the active shift register.
REQ-008 SHALL have port tdoEnable  output  1  high only in shiftIr/shiftDr.
REQ-009 SHALL have port boundaryScanIn  input  TEST_VECTOR_WIDTH  parallel value captured into the boundary-scan register.
REQ-010 SHALL have port tapState  output  4  current state, encoded 0..15 in JtagTapStates order (reset=0, idle=1 ... updateDr=15).
REQ-011 SHALL have port instructionOut  output  INSTRUCTION_WIDTH  latched instruction.
REQ-012 SHALL have port userRegOut  output  TEST_VECTOR_WIDTH  updated user-defined register.
REQ-013 SHALL have port boundaryScanOut  output  TEST_VECTOR_WIDTH  updated boundary-scan register.
REQ-014 SHALL have port updateDrPulse  output  1  one-cycle pulse while in updateDr.

Function
REQ-015 TAP FSM SHALL follow IEEE 1149.1: reset-(0)->idle; idle-(1)->drScan; drScan-(1)->irScan, (0)->captureDr; irScan-(1)->reset, (0)->captureIr; capture-(0)->shift, (1)->exit1; shift-(1)->exit1; exit1-(0)->pause, (1)->update; pause-(1)->exit2; exit2-(0)->shift, (1)->update; update-(1)->drScan, (0)->idle; unlisted Tms values hold state.
REQ-016 Five consecutive clk edges with Tms=1 SHALL reach reset from any state.
REQ-017 In reset state, instruction SHALL load bypass (5'b00000 truncated to INSTRUCTION_WIDTH).
REQ-018 captureIr SHALL load IR shift register with ...0001 (LSBs 2'b01, rest 0).
REQ-019 shiftIr/shiftDr: each edge SHALL shift right, Tdi into MSB; Tdo = current LSB (combinational); Tdo=0 outside shift states.
REQ-020 updateIr SHALL copy IR shift register to instructionOut.
REQ-021 Opcode decode: 00001 -> user-defined register; 00110 -> boundary-scan register; 00000 and all undefined opcodes -> 1-bit bypass register.
REQ-022 captureDr SHALL load: bypass 0; user register its current userRegOut; boundary register boundaryScanIn.
REQ-023 updateDr SHALL copy the selected shift register to userRegOut or boundaryScanOut; bypass updates nothing; updateDrPulse high that cycle regardless.
REQ-024 Bypass path SHALL give exactly one clk of Tdi->Tdo delay.
REQ-025 Pause/exit states SHALL hold shift register contents unchanged.
REQ-026 Shifting more bits than register length SHALL simply continue the shift (oldest bits lost), no error.

Reset
REQ-027 reset assertion SHALL immediately force: tapState=0, instructionOut=bypass, all shift registers 0, userRegOut=0, boundaryScanOut=0, Tdo=0, tdoEnable=0, updateDrPulse=0.
REQ-028 reset mid-shift SHALL discard partial data; no update occurs.

Configuration
REQ-029 With JTAG_TRST_EN defined, SHALL add port Trst input 1 (active-low async); Trst=0 forces TAP-only reset (tapState=0, instructionOut=bypass, tdoEnable=0) but SHALL preserve userRegOut/boundaryScanOut.
REQ-030 Without JTAG_TRST_EN, port Trst SHALL not exist; only Tms sequence and reset reset the TAP.

Verification
REQ-031 reset then Tms=1,1,1,1,1 from shiftDr -> tapState=0 on 5th edge, instructionOut=0.
REQ-032 Tms 0,1,1,0,0 then shift IR 5'b00001 (Tms=0x4,1), 1,0 -> instructionOut=00001; Tdo during shiftIr emits 1,0,0,0,0.
REQ-033 With IR=00001, shift 32'hA5A5_1234 through DR, exit1->updateDr -> userRegOut=32'hA5A5_1234, updateDrPulse one cycle.
REQ-034 IR=00110, boundaryScanIn=32'hDEAD_BEEF -> captureDr then 32 shifts -> Tdo bit sequence of 32'hDEAD_BEEF LSB first.
REQ-035 IR=5'b11111 (undefined), Tdi pattern 1,0,1,1 in shiftDr -> Tdo 0,1,0,1 (one-bit delay).
REQ-036 Assert reset mid shiftDr after 10 bits -> all outputs zero immediately, userRegOut unchanged at 0.
